div_ratio_ctrl: RTL
===================

# div_ratio_ctrl

Division-ratio controller for the dual-modulus (4/5) pulse-swallow divider. Once per output period it computes the next instantaneous ratio from an integer word plus a first-order fractional accumulator. It splits that ratio into the programmable-counter load value `Pi` and the swallow count `Si`, and presents both one period ahead of the counter load. Configuration writes go through a shadow-register handshake and take effect only at a load boundary, so the counters never see a torn ratio.

## Interface
- `WIDTH`, default 5: width of `Pi`. Ratio width is `WIDTH+2`.
- `FRAC_W`, default 8: width of the fractional word and the accumulator.
- `RST_NDIV`, default 20: active integer ratio after reset. Must satisfy the range rule.

Ports:
- `Fin` in 1: clock, the prescaler-output clock that also drives the P counter.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ld` in 1: load strobe from the P counter. High for exactly one `Fin` cycle per output period.
- `cfg_we` in 1: one-cycle write strobe for `cfg_nint` and `cfg_frac`.
- `cfg_nint` in `WIDTH+2`: new integer ratio.
- `cfg_frac` in `FRAC_W`: new fraction, as a count in units of 2^-FRAC_W.
- `cfg_pend` out 1: shadow holds a write that has not yet been applied.
- `Pi` out `WIDTH`: P load value, equal to `n_cur>>2`.
- `Si` out 2: swallow count, equal to `n_cur[1:0]`.
- `n_cur` out `WIDTH+2`: instantaneous ratio currently presented.
- `carry` out 1: accumulator overflow that produced `n_cur`.
- `range_err` out 1: sticky flag, set when a computed ratio was rejected.

## Operation
- Registers:
  - Active config: `n_act`, `f_act`.
  - Shadow config: `n_sh`, `f_sh`, plus `cfg_pend`.
  - Accumulator: `acc[FRAC_W-1:0]`.
  - Output registers: `Pi`, `Si`, `n_cur`, `carry`.
  - Flag: `range_err`.
- Reset state:
  - `n_act = n_sh = RST_NDIV`.
  - `f_act = f_sh = 0`.
  - `acc = 0`.
  - `n_cur = RST_NDIV`, `Pi = RST_NDIV>>2`, `Si = RST_NDIV[1:0]`.
  - `carry = 0`, `cfg_pend = 0`, `range_err = 0`.
- States: `IDLE` (reset released, no `ld` seen yet) and `RUN`. The first `ld` moves the block to `RUN`. Outputs keep their reset values until that first `ld`.
- Per `ld` edge, in `RUN` or on the first `ld`:
  1. If `cfg_pend=1`: copy shadow to active, clear `acc` to 0 before this edge's addition, clear `range_err`, and clear `cfg_pend`.
  2. Compute `{c, a} = acc + f_act` as `FRAC_W+1` bits, where `f_act` is the value after step 1. Then `n_next = n_act + c`, carried at `WIDTH+2` bits.
  3. Range rule: `n_next>>2 >= 2` and `n_next>>2 >= n_next[1:0]`, with no overflow out of `WIDTH+2` bits.
  4. If the rule holds: update `acc=a`, `n_cur=n_next`, `Pi`, `Si`, and `carry=c`.
  5. If the rule fails: `acc` still advances to `a`, all outputs hold their previous values, and `range_err` is set to 1.
- Config handshake:
  - `cfg_we=1` always loads the shadow and sets `cfg_pend=1`. The most recent write wins.
  - `cfg_we` and `ld` in the same cycle with `cfg_pend=0`: the write lands in the shadow and is applied at the following `ld`, not this one.
  - `cfg_we` and `ld` in the same cycle with `cfg_pend=1`: the old shadow is applied at this `ld`. The new write is captured and `cfg_pend` stays 1.
- Integer mode is `f_act=0`: `carry` is always 0 and `n_cur` stays constant.

## Timing
- All outputs are registered on rising `Fin`, except the asynchronous clear on `rst_n` low.
- Latency is one cycle from `ld` sampled high to new `Pi`/`Si` being valid. The values are stable for the whole following period and are used by the counters at the next load.
- `cfg_pend` rises in the cycle after `cfg_we` and falls in the cycle after the applying `ld`.
- `rst_n` asserted mid-period forces reset values immediately and discards any pending shadow. After release, the block waits in `IDLE` for `ld`.
- `ld` held high for several cycles is illegal. Each sampled-high cycle counts as a separate load.

## Test plan
- **Reset.** Assert `rst_n=0` mid-run. Required: `Pi=5`, `Si=0`, `n_cur=20`, `cfg_pend=0`, `range_err=0` immediately. After release and the first `ld`, outputs are unchanged.
- **Integer write.** Write `cfg_nint=23`, `cfg_frac=0`, then pulse `ld`. Required: `Pi=5`, `Si=3` one cycle later, `cfg_pend` 1→0, and `carry` always 0 over 8 further `ld` pulses.
- **Fraction 0.5.** Write `cfg_nint=20`, `cfg_frac=128`. Required: successive `n_cur` = 20, 21, 20, 21, with `Si` = 0, 1, 0, 1. Over 256 loads the average ratio is exactly 20.5.
- **Fraction 0.25.** Write `cfg_nint=20`, `cfg_frac=64`. Required: `carry` is high on every 4th `ld` only, giving `n_cur` = 20, 20, 20, 21, repeating.
- **Range.**
  - Write `cfg_nint=9`. Required: `Pi=2`, `Si=1`, accepted.
  - Then write `cfg_nint=7`. Required: outputs stay at 9, `range_err=1`.
  - Then write `cfg_nint=12`. Required: `range_err` clears at the applying `ld`, with `Pi=3`, `Si=0`.
- **Simultaneous events.**
  - `cfg_we` (N=24) coincident with `ld` while `cfg_pend=0`. Required: that `ld` keeps the old N, and the next `ld` gives `Pi=6`, `Si=0`.
  - Repeat the coincidence while `cfg_pend=1`. Required: the pending value is applied, and `cfg_pend` remains 1.

Source files
------------

// File: rtl/div_ratio_ctrl_if.sv
// Configuration handshake and ratio outputs of the pulse-swallow ratio controller.
// The controller uses the slave modport; whatever drives ld and config uses master.
interface div_ratio_ctrl_if #(
  parameter int WIDTH  = 5,
  parameter int FRAC_W = 8
);
  logic              ld;
  logic              cfg_we;
  logic [WIDTH+1:0]  cfg_nint;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_pend;
  logic [WIDTH-1:0]  Pi;
  logic [1:0]        Si;
  logic [WIDTH+1:0]  n_cur;
  logic              carry;
  logic              range_err;

  modport master (
    output ld, cfg_we, cfg_nint, cfg_frac,
    input  cfg_pend, Pi, Si, n_cur, carry, range_err
  );

  modport slave (
    input  ld, cfg_we, cfg_nint, cfg_frac,
    output cfg_pend, Pi, Si, n_cur, carry, range_err
  );
endinterface

// File: rtl/div_ratio_ctrl.sv
// Division-ratio controller for a 4/5 pulse-swallow divider: integer word plus a
// first-order fractional accumulator, split into P load and swallow count per period.
module div_ratio_ctrl #(
  parameter int WIDTH    = 5,
  parameter int FRAC_W   = 8,
  parameter int RST_NDIV = 20
) (
  input logic              Fin,
  input logic              rst_n,
  div_ratio_ctrl_if.slave  bus
);
  localparam int NW = WIDTH + 2;
  localparam logic [NW-1:0] RST_N_VEC = NW'(RST_NDIV);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic [NW-1:0]     n_act_reg, n_act_next;
  logic [FRAC_W-1:0] f_act_reg, f_act_next;
  logic [NW-1:0]     n_sh_reg, n_sh_next;
  logic [FRAC_W-1:0] f_sh_reg, f_sh_next;
  logic              pend_reg, pend_next;
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]  pi_reg, pi_next;
  logic [1:0]        si_reg, si_next;
  logic [NW-1:0]     n_cur_reg, n_cur_next;
  logic              carry_reg, carry_next;
  logic              rerr_reg, rerr_next;

  // Datapath for the ratio that this ld would produce
  logic              apply;
  logic [NW-1:0]     n_eff;
  logic [FRAC_W-1:0] f_eff;
  logic [FRAC_W-1:0] acc_base;
  logic [FRAC_W:0]   sum;
  logic              sum_c;
  logic [NW:0]       n_wide;
  logic [NW-1:0]     n_next;
  logic [WIDTH-1:0]  p_next;
  logic              range_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.ld) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // A pending shadow is applied at this ld, restarting the accumulator from zero
  assign apply    = bus.ld & pend_reg;
  assign n_eff    = apply ? n_sh_reg : n_act_reg;
  assign f_eff    = apply ? f_sh_reg : f_act_reg;
  assign acc_base = apply ? '0 : acc_reg;
  assign sum      = {1'b0, acc_base} + {1'b0, f_eff};
  assign sum_c    = sum[FRAC_W];
  assign n_wide   = {1'b0, n_eff} + {{NW{1'b0}}, sum_c};
  assign n_next   = n_wide[NW-1:0];
  assign p_next   = n_next[NW-1:2];
  assign range_ok = !n_wide[NW] && (p_next >= WIDTH'(2)) &&
                    (p_next >= {{(WIDTH-2){1'b0}}, n_next[1:0]});

  always_comb begin
    n_act_next = n_act_reg;
    f_act_next = f_act_reg;
    n_sh_next  = n_sh_reg;
    f_sh_next  = f_sh_reg;
    pend_next  = pend_reg;
    acc_next   = acc_reg;
    pi_next    = pi_reg;
    si_next    = si_reg;
    n_cur_next = n_cur_reg;
    carry_next = carry_reg;
    rerr_next  = rerr_reg;

    if (bus.ld) begin
      if (apply) begin
        n_act_next = n_sh_reg;
        f_act_next = f_sh_reg;
        rerr_next  = 1'b0;
      end
      // The accumulator advances even when the ratio is rejected
      acc_next = sum[FRAC_W-1:0];
      if (range_ok) begin
        n_cur_next = n_next;
        pi_next    = p_next;
        si_next    = n_next[1:0];
        carry_next = sum_c;
      end else begin
        rerr_next = 1'b1;
      end
    end

    // A write coincident with an applying ld lands after the old shadow is consumed
    if (bus.cfg_we) begin
      n_sh_next = bus.cfg_nint;
      f_sh_next = bus.cfg_frac;
      pend_next = 1'b1;
    end else if (apply) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge Fin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_act_reg <= RST_N_VEC;
      f_act_reg <= '0;
      n_sh_reg  <= RST_N_VEC;
      f_sh_reg  <= '0;
      pend_reg  <= 1'b0;
      acc_reg   <= '0;
      pi_reg    <= RST_N_VEC[NW-1:2];
      si_reg    <= RST_N_VEC[1:0];
      n_cur_reg <= RST_N_VEC;
      carry_reg <= 1'b0;
      rerr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_act_reg <= n_act_next;
      f_act_reg <= f_act_next;
      n_sh_reg  <= n_sh_next;
      f_sh_reg  <= f_sh_next;
      pend_reg  <= pend_next;
      acc_reg   <= acc_next;
      pi_reg    <= pi_next;
      si_reg    <= si_next;
      n_cur_reg <= n_cur_next;
      carry_reg <= carry_next;
      rerr_reg  <= rerr_next;
    end
  end

  assign bus.cfg_pend  = pend_reg;
  assign bus.Pi        = pi_reg;
  assign bus.Si        = si_reg;
  assign bus.n_cur     = n_cur_reg;
  assign bus.carry     = carry_reg;
  assign bus.range_err = rerr_reg;
endmodule
